// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM states,
// instruction width and the default base address shared with the IFU reset PC.
package imem_responder_pkg;

  localparam int unsigned INSN_W = 32;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction storage: synchronous preload write port and a
// combinational read port. Contents are deliberately not reset.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [INSN_W-1:0]              wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [INSN_W-1:0]              rdata
);

  logic [INSN_W-1:0] mem_r [DEPTH_WORDS];

  // Preload write; a read of the same word this cycle still sees the old value
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/imem_responder.sv
// Memory end of the instruction-fetch interface: accepts one fetch at a time,
// checks alignment/range and returns the word after a fixed latency.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [INSN_W-1:0]              resp_data,
  output logic                           resp_err,
  input  logic                           init_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] init_addr,
  input  logic [INSN_W-1:0]              init_data
);

  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1      = 4'(LATENCY - 32'd1);
  localparam state_e      ACCEPT_NEXT = (LATENCY == 32'd1) ? ST_RESP : ST_WAIT;
  // 33-bit bounds so a fetch near 32'hFFFF_FFFC cannot wrap into range
  localparam logic [32:0] BASE_33     = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_33    = BASE_33 + 33'(DEPTH_WORDS * 32'd4);

  state_e             state_r;
  state_e             state_s;
  logic [3:0]         cnt_r;
  logic [3:0]         cnt_s;
  logic [31:0]        addr_r;
  logic               req_ready_r;
  logic               resp_valid_r;
  logic [INSN_W-1:0]  resp_data_r;
  logic               resp_err_r;

  logic               accept_s;
  logic               capture_s;
  logic [31:0]        cap_addr_s;
  logic [32:0]        addr33_s;
  logic               fault_s;
  logic [IDX_W-1:0]   rd_idx_s;
  logic [INSN_W-1:0]  rd_data_s;
  logic               wr_en_s;

  assign accept_s  = (state_r == ST_IDLE) && req_valid && req_ready_r;
  assign capture_s = (state_s == ST_RESP) && (state_r != ST_RESP);
  assign wr_en_s   = init_we && !rst;

  // Next-state and latency counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          cnt_s   = LAT_M1;
          state_s = ACCEPT_NEXT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_valid_r && resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Address check; with one-cycle latency the capture happens on the accept edge
  always_comb begin
    if (state_r == ST_IDLE) begin
      cap_addr_s = req_addr;
    end else begin
      cap_addr_s = addr_r;
    end
    addr33_s = {1'b0, cap_addr_s};
    if ((cap_addr_s[1:0] != 2'b00) || (addr33_s < BASE_33) || (addr33_s >= LIMIT_33)) begin
      fault_s = 1'b1;
    end else begin
      fault_s = 1'b0;
    end
    rd_idx_s = IDX_W'((cap_addr_s - BASE_ADDR) >> 2);
  end

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (init_addr),
    .wdata (init_data),
    .raddr (rd_idx_s),
    .rdata (rd_data_s)
  );

  // State, latched address and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      addr_r       <= 32'd0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_data_r  <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      req_ready_r  <= (state_s == ST_IDLE);
      resp_valid_r <= (state_s == ST_RESP);
      if (accept_s) begin
        addr_r <= req_addr;
      end
      if (capture_s) begin
        resp_err_r  <= fault_s;
        resp_data_r <= fault_s ? 32'd0 : rd_data_s;
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_err   = resp_err_r;

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the instruction-fetch interface; the IFU is the initiator.
- Accepts one fetch request at a time over a valid/ready request channel. Looks up a word-addressed array and returns the instruction over a valid/ready response channel after a fixed, parameterised latency.
- Carries a preload write port so benches and simulation harnesses can load program images before releasing the core.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 1, cycles from request accept to first cycle of resp_valid; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  fetch request valid.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address of the fetch.
- resp_valid  output  1  response valid.
- resp_ready  input  1  initiator accepts the response.
- resp_data  output  32  fetched instruction word.
- resp_err  output  1  access fault (misaligned or out of range).
- init_we  input  1  preload write enable.
- init_addr  input  $clog2(DEPTH_WORDS)  preload word index.
- init_data  input  32  preload write data.

Behaviour:
- Reset values:
  - FSM to IDLE.
  - req_ready=1 in the first cycle after reset.
  - resp_valid=0, resp_data=0, resp_err=0, latency counter=0.
  - Array contents are not reset.
- Reset mid-operation:
  - Any pending request or held response is dropped without being delivered.
  - init_we is ignored while rst=1.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready (accept edge), latch req_addr and load the counter with LATENCY-1.
  - Next state is RESP if LATENCY==1, otherwise WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter reaches 1, go to RESP on the next edge.
- Data capture:
  - resp_data and resp_err are registered on the edge that enters RESP.
  - Timing: accept at edge N gives resp_valid=1 from edge N+LATENCY onward.
- RESP:
  - req_ready=0.
  - resp_valid, resp_data and resp_err are held stable until resp_valid&&resp_ready.
  - On that handshake edge: go to IDLE, clear resp_valid, leave resp_data unchanged.
- Throughput:
  - One outstanding request at most; no accept in the same cycle as a response handshake.
  - Best case is one fetch per LATENCY+1 cycles.
- Error detection, evaluated on the latched address:
  - Misaligned: addr[1:0]!=0.
  - Out of range: addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS. Compute with 33-bit arithmetic so no wrap occurs at the top of the address space.
  - On error: resp_err=1 and resp_data=0.
- Index: word index is (addr-BASE_ADDR)>>2, truncated to $clog2(DEPTH_WORDS) bits only after the range check.
- Preload:
  - init_we writes init_data to init_addr on the edge, in any FSM state.
  - If a write and a data capture hit the same word on the same edge, the capture returns the old value (read-before-write).
- Protocol invariants:
  - req_addr is sampled only on the accept edge.
  - Changes to req_valid/req_addr while req_ready=0 have no effect.
  - resp_valid never deasserts without a handshake, except on rst.

Decomposition:
- Shared package holds:
  - The FSM state enum (IDLE/WAIT/RESP).
  - The default BASE_ADDR constant, shared with the IFU reset PC.
  - The INSN_W=32 width constant.
- One sub-module, imem_array:
  - DEPTH_WORDS x 32 storage.
  - Synchronous write port driven by init_we/init_addr/init_data.
  - Combinational read port indexed by word index.
- The FSM, latency counter, range check and output registers stay in imem_responder.

Test Plan:
1. Preload word 0 with 32'h0000_0413 and word 1 with 32'h0010_0093. With LATENCY=1 and resp_ready tied 1, request 32'h8000_0000 then 32'h8000_0004. Required: resp_data 32'h0000_0413 one cycle after the first accept, then 32'h0010_0093, resp_err=0 for both, one fetch per 2 cycles.
2. With LATENCY=4, accept at cycle 10. Required: resp_valid first high at cycle 14 and req_ready low during cycles 11-14.
3. Hold resp_ready=0 for 5 cycles in RESP while toggling req_valid and req_addr. Required: resp_data and resp_valid stable, req_ready=0 throughout, IDLE one cycle after resp_ready rises.
4. Error cases:
   - Request 32'h8000_0002. Required: resp_err=1, resp_data=0.
   - Request 32'h7FFF_FFFC and 32'h8000_1000 with DEPTH_WORDS=1024. Required: resp_err=1 for each.
   - Request 32'hFFFF_FFFC. Required: resp_err=1, with no wrap to a valid index.
5. Assert rst during WAIT with LATENCY=3. Required: resp_valid never rises for that request, and req_ready=1 the cycle after rst drops.
6. Write word 2 with init_we on the same edge the responder captures word 2 (old value 32'hAAAA_AAAA, new 32'h5555_5555). Required: resp_data=32'hAAAA_AAAA, and the next fetch of word 2 returns 32'h5555_5555.
